// File: rtl/tmds_channel_ctrl.sv
// tmds_channel_ctrl
//   One HDMI TMDS channel (0=blue, 1=green, 2=red). It delays the incoming
//   pixel, control and video-enable stream by DLY cycles. It sequences the
//   channel through control, preamble, guard band and active video, then
//   emits a registered 10-bit symbol. In active video the symbol is the
//   8b->9b transition-minimized byte with DC-balance selection driven by a
//   running disparity tally.
//
//   Ports
//     clk_in        pixel clock
//     rst_in        synchronous active-high reset
//     video_data_in pixel byte for this channel
//     control_in    {c1,c0}; channel 0 carries {vsync,hsync}
//     ve_in         video enable (active-video period)
//     tmds_out      registered TMDS symbol to the serializer
//     err_out       sticky: a blanking interval was too short for
//                   preamble + guard band
//
//   Timing
//     An input sampled on edge E reaches tmds_out after edge E+10. That is
//     10 delay stages plus the output register.
//     The FSM register holds the period of the symbol currently on tmds_out.
//     The combinational block below decides the period of the symbol being
//     registered now. It bases that decision on the undelayed ve_in, so a
//     ve_in rise can open the preamble for the 10 output slots that come
//     before the first video symbol.
module tmds_channel_ctrl #(
  parameter int CHANNEL   = 0,
  parameter bit HDMI_MODE = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] video_data_in,
  input  logic [1:0] control_in,
  input  logic       ve_in,
  output logic [9:0] tmds_out,
  output logic       err_out
);

  localparam int DLY       = 10;
  localparam int BLANK_MIN = 12;

  localparam logic [9:0] SYM_C00   = 10'b1101010100;
  localparam logic [9:0] SYM_C01   = 10'b0010101011;
  localparam logic [9:0] SYM_C10   = 10'b0101010100;
  localparam logic [9:0] SYM_C11   = 10'b1010101011;
  localparam logic [9:0] SYM_GB_02 = 10'b1011001100;
  localparam logic [9:0] SYM_GB_1  = 10'b0100110011;

  typedef enum logic [1:0] {
    ST_CTRL     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_GUARD    = 2'd2,
    ST_VIDEO    = 2'd3
  } state_t;

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   ctrl_sym = SYM_C00;
      2'b01:   ctrl_sym = SYM_C01;
      2'b10:   ctrl_sym = SYM_C10;
      default: ctrl_sym = SYM_C11;
    endcase
  endfunction

  // ---------------------------------------------------------------- delay line
  logic [DLY-1:0] ve_dly;
  logic [1:0]     ctrl_dly [DLY];
  logic [7:0]     data_dly [DLY];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ve_dly <= '0;
      for (int i = 0; i < DLY; i++) begin
        ctrl_dly[i] <= 2'b00;
        data_dly[i] <= 8'h00;
      end
    end else begin
      ve_dly      <= {ve_dly[DLY-2:0], ve_in};
      ctrl_dly[0] <= control_in;
      data_dly[0] <= video_data_in;
      for (int i = 1; i < DLY; i++) begin
        ctrl_dly[i] <= ctrl_dly[i-1];
        data_dly[i] <= data_dly[i-1];
      end
    end
  end

  logic       d_ve;
  logic [1:0] d_ctrl;
  logic [7:0] d_data;

  assign d_ve   = ve_dly[DLY-1];
  assign d_ctrl = ctrl_dly[DLY-1];
  assign d_data = data_dly[DLY-1];

  // ------------------------------------------------- blanking length tracking
  // blank_cnt saturates at BLANK_MIN; it only needs to answer "long enough".
  logic       ve_prev;
  logic [3:0] blank_cnt;
  logic       ve_rise;
  logic       blank_ok;

  assign ve_rise  = ve_in & ~ve_prev;
  assign blank_ok = (blank_cnt >= 4'(BLANK_MIN));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ve_prev   <= 1'b0;
      blank_cnt <= 4'd0;
    end else begin
      ve_prev <= ve_in;
      if (ve_in)
        blank_cnt <= 4'd0;
      else if (!blank_ok)
        blank_cnt <= blank_cnt + 4'd1;
    end
  end

  // ------------------------------------------------------------------- FSM
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_CTRL;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // A rising ve_in after a short blanking cannot fit preamble + guard.
    // That line then starts in plain DVI fashion, and the error is recorded.
    if (HDMI_MODE && ve_rise && !blank_ok)
      err_d = 1'b1;

    case (state_q)
      ST_CTRL: begin
        if (HDMI_MODE && ve_rise && blank_ok) begin
          state_d = ST_PREAMBLE;
          cnt_d   = 3'd0;
        end else if (d_ve) begin
          state_d = ST_VIDEO;
        end
      end
      ST_PREAMBLE: begin
        if (cnt_q == 3'd7) begin
          state_d = ST_GUARD;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == 3'd1) begin
          state_d = d_ve ? ST_VIDEO : ST_CTRL;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_VIDEO: begin
        if (!d_ve)
          state_d = ST_CTRL;
      end
      default: begin
        state_d = ST_CTRL;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // ----------------------------------------------------------- video encode
  logic              [3:0] ones_d;
  logic                    use_xnor;
  logic              [8:0] q_m;
  logic              [3:0] n1;
  logic signed       [5:0] n1_minus_n0;
  logic signed       [5:0] delta;
  logic signed       [5:0] tally_ext;
  logic signed       [5:0] tally_sum;
  logic signed       [4:0] tally_q, tally_d;
  logic              [9:0] video_sym;

  always_comb begin
    ones_d = 4'd0;
    for (int i = 0; i < 8; i++)
      ones_d = ones_d + {3'b000, d_data[i]};

    use_xnor = (ones_d > 4'd4) || ((ones_d == 4'd4) && !d_data[0]);

    q_m    = 9'd0;
    q_m[0] = d_data[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ d_data[i]) : (q_m[i-1] ^ d_data[i]);
    q_m[8] = ~use_xnor;

    n1 = 4'd0;
    for (int i = 0; i < 8; i++)
      n1 = n1 + {3'b000, q_m[i]};

    // N1 - N0 = 2*N1 - 8 for an 8-bit word.
    n1_minus_n0 = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    tally_ext   = {tally_q[4], tally_q};

    if ((tally_q == 5'sd0) || (n1 == 4'd4)) begin
      video_sym = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      delta     = q_m[8] ? n1_minus_n0 : -n1_minus_n0;
    end else if ((!tally_q[4] && (n1 > 4'd4)) || (tally_q[4] && (n1 < 4'd4))) begin
      video_sym = {1'b1, q_m[8], ~q_m[7:0]};
      delta     = (q_m[8] ? 6'sd2 : 6'sd0) - n1_minus_n0;
    end else begin
      video_sym = {1'b0, q_m[8], q_m[7:0]};
      delta     = n1_minus_n0 - (q_m[8] ? 6'sd0 : 6'sd2);
    end

    tally_sum = tally_ext + delta;
  end

  // ------------------------------------------------------------ symbol mux
  logic [1:0] pre_ctrl;
  logic [9:0] sym_d;

  always_comb begin
    pre_ctrl = d_ctrl;
    if (CHANNEL == 1)
      pre_ctrl = 2'b01;
    else if (CHANNEL == 2)
      pre_ctrl = 2'b00;

    sym_d   = ctrl_sym(d_ctrl);
    tally_d = 5'sd0;
    case (state_d)
      ST_PREAMBLE: sym_d = ctrl_sym(pre_ctrl);
      ST_GUARD:    sym_d = (CHANNEL == 1) ? SYM_GB_1 : SYM_GB_02;
      ST_VIDEO: begin
        sym_d   = video_sym;
        tally_d = tally_sum[4:0];
      end
      default:     sym_d = ctrl_sym(d_ctrl);
    endcase
  end

  logic [9:0] tmds_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tmds_q  <= SYM_C00;
      tally_q <= 5'sd0;
    end else begin
      tmds_q  <= sym_d;
      tally_q <= tally_d;
    end
  end

  assign tmds_out = tmds_q;
  assign err_out  = err_q;

endmodule
